// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin grant scheduler sharing one resource between NUM_REQ requesters.
//
// A registered one-hot grant is held while the owner keeps its request asserted. The grant is
// limited to MAX_HOLD consecutive cycles, and one idle turnaround cycle (PARK) separates owners.
// gnt_id is intended as the select of the downstream datapath mux.
//
// Ports:
//   clock    in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req      in   [NUM_REQ] level request vector, bit i = requester i
//   gnt      out  [NUM_REQ] registered one-hot grant, zero when no owner
//   gnt_id   out  [IDW] index of current owner, valid only when gnt != 0 (held otherwise)
//   busy     out  high whenever the scheduler is not idle
//   timeout  out  one-cycle pulse when a grant is revoked by the hold limit
//   preempt  out  (only with RR_GRANT_SCHED_PREEMPT_EN) one-cycle pulse on urgent revocation
//
// Optional feature macro: RR_GRANT_SCHED_PREEMPT_EN makes requester 0 urgent; it revokes any
// other owner and wins the following arbitration regardless of round-robin position.

module rr_grant_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
`ifdef RR_GRANT_SCHED_PREEMPT_EN
  output logic               preempt,
`endif
  output logic               timeout
);

  // MAX_HOLD == 0 disables the limit; keep a 1-bit counter so widths stay legal.
  localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StGnt  = 3'b010,
    StPark = 3'b100
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [IDW-1:0]       last_id_q, last_id_d;
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 preempt_q, preempt_d;

  logic [IDW-1:0]       scan_id;
  logic [IDW-1:0]       win_id;
  logic                 win_vld;
  logic [IDW-1:0]       sel_id;
  logic                 at_limit;

  // Rotating priority: scan last_id+1, last_id+2, ... so the previous winner is checked last.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    scan_id = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_id = IDW'((32'(last_id_q) + i) % NUM_REQ);
      if (!win_vld && req[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  assign at_limit = (MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    preempt_d  = 1'b0;
    sel_id     = win_id;
`ifdef RR_GRANT_SCHED_PREEMPT_EN
    // The arbitration right after a preemption goes to the urgent requester.
    if (state_q == StPark && preempt_q && req[0]) begin
      sel_id = '0;
    end
`endif

    unique case (state_q)
      StIdle, StPark: begin
        if (win_vld) begin
          state_d    = StGnt;
          gnt_d      = NUM_REQ'(1) << sel_id;
          gnt_id_d   = sel_id;
          last_id_d  = sel_id;
          hold_cnt_d = '0;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StGnt: begin
        // A release wins over both preemption and the hold limit.
        if (!req[gnt_id_q]) begin
          state_d = StPark;
          gnt_d   = '0;
`ifdef RR_GRANT_SCHED_PREEMPT_EN
        end else if (req[0] && (gnt_id_q != '0)) begin
          state_d   = StPark;
          gnt_d     = '0;
          preempt_d = 1'b1;
`endif
        end else if (at_limit) begin
          state_d   = StPark;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      last_id_q  <= IDW'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q != StIdle);
  assign timeout = timeout_q;
`ifdef RR_GRANT_SCHED_PREEMPT_EN
  assign preempt = preempt_q;
`endif

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed testbench for rr_grant_sched (NUM_REQ=4, MAX_HOLD=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.

module tb_rr_grant_sched;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] req     = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
`ifdef RR_GRANT_SCHED_PREEMPT_EN
  logic       preempt;
`endif

  int checks   = 0;
  int failures = 0;

  rr_grant_sched #(
    .NUM_REQ  (4),
    .MAX_HOLD (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
`ifdef RR_GRANT_SCHED_PREEMPT_EN
    .preempt (preempt),
`endif
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    req     = 4'b0000;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_hold_gnt got=%b exp=0000", gnt); end
    req     = 4'b0000;
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  // All four requesting: 8-cycle grants with a timeout PARK between owners, rotating 0,1,2,3,0.
  task automatic test_all_req();
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int id;
      id = k % 4;
      for (int c = 0; c < 8; c++) begin
        tick();
        checks++;
        if (gnt !== 4'(1 << id) || gnt_id !== 2'(id) || timeout !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL all_req_grant k=%0d c=%0d got gnt=%b id=%0d to=%b busy=%b exp gnt=%b id=%0d to=0 busy=1",
                   k, c, gnt, gnt_id, timeout, busy, 4'(1 << id), id);
        end
      end
      if (k < 4) begin
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL all_req_park k=%0d got gnt=%b to=%b busy=%b exp gnt=0000 to=1 busy=1",
                   k, gnt, timeout, busy);
        end
      end
    end
    req = 4'b0000;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL all_req_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_short_grant();
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
        failures++;
        $display("FAIL short_grant c=%0d got gnt=%b id=%0d busy=%b exp gnt=0100 id=2 busy=1",
                 c, gnt, gnt_id, busy);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || timeout !== 1'b0 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL short_park got gnt=%b busy=%b to=%b id=%0d exp gnt=0000 busy=1 to=0 id=2",
               gnt, busy, timeout, gnt_id);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL short_idle got gnt=%b busy=%b id=%0d exp gnt=0000 busy=0 id=2", gnt, busy, gnt_id);
    end
  endtask

  // A lone requester is re-granted after each forced PARK; every 9th cycle is a timeout PARK.
  task automatic test_hold_alone();
    apply_reset();
    req = 4'b0010;
    for (int e = 1; e <= 20; e++) begin
      logic       park;
      logic [3:0] exp_gnt;
      tick();
      park    = (e % 9 == 0);
      exp_gnt = park ? 4'b0000 : 4'b0010;
      checks++;
      if (gnt !== exp_gnt || timeout !== park) begin
        failures++;
        $display("FAIL hold_alone e=%0d got gnt=%b to=%b exp gnt=%b to=%b", e, gnt, timeout, exp_gnt, park);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Owner 3 releases exactly when the hold limit would fire: a release, no timeout.
  task automatic test_release_at_limit();
    apply_reset();
    req = 4'b1000;
    for (int e = 1; e <= 8; e++) tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL limit_pre got gnt=%b id=%0d exp gnt=1000 id=3", gnt, gnt_id);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL limit_release got gnt=%b to=%b busy=%b exp gnt=0000 to=0 busy=1", gnt, timeout, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL limit_next got gnt=%b id=%0d to=%b exp gnt=0001 id=0 to=0", gnt, gnt_id, timeout);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL async_pre got gnt=%b exp=0010", gnt); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL async_clear got gnt=%b busy=%b id=%0d exp gnt=0000 busy=0 id=0", gnt, busy, gnt_id);
    end
    reset_n = 1'b1;
    req     = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL async_first got gnt=%b id=%0d exp gnt=0001 id=0", gnt, gnt_id);
    end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL async_park got gnt=%b exp=0000", gnt); end
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      failures++;
      $display("FAIL async_second got gnt=%b id=%0d exp gnt=0010 id=1", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

`ifdef RR_GRANT_SCHED_PREEMPT_EN
  // Owner 2 is revoked by requester 0; requester 3 would be next by rotation but 0 wins.
  task automatic test_preempt();
    apply_reset();
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL preempt_pre got gnt=%b exp=0100", gnt); end
    req = 4'b1101;
    tick();
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL preempt_revoke got gnt=%b pre=%b to=%b exp gnt=0000 pre=1 to=0", gnt, preempt, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL preempt_grant got gnt=%b id=%0d pre=%b exp gnt=0001 id=0 pre=0", gnt, gnt_id, preempt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifndef RR_GRANT_SCHED_PREEMPT_EN
    test_all_req();
`endif
    test_short_grant();
    test_hold_alone();
    test_release_at_limit();
    test_async_reset();
`ifdef RR_GRANT_SCHED_PREEMPT_EN
    test_preempt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_grant_sched.md
Name: rr_grant_sched

Overview:
- Round-robin grant scheduler that shares one resource (bus/port) between NUM_REQ requesters.
- Issues a one-hot grant and holds it while the owner keeps its request asserted.
- Enforces a maximum hold time and inserts a one-cycle turnaround between owners.
- Sits between requester FSMs and the shared datapath mux; gnt_id drives the mux select.

Parameters:
- NUM_REQ, 4: number of requesters, >=2.
- MAX_HOLD, 8: maximum consecutive grant cycles per owner; 0 disables the timeout.
- IDW, $clog2(NUM_REQ): width of gnt_id, derived; do not override.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request vector, level; bit i = requester i.
- gnt  output  NUM_REQ  one-hot grant, registered; all zero when no owner.
- gnt_id  output  IDW  index of current owner; valid only when gnt != 0.
- busy  output  1  high whenever state != IDLE.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - gnt=0, gnt_id=0, busy=0, timeout=0, state=IDLE, hold_cnt=0.
  - last_id=NUM_REQ-1, so requester 0 wins first.
- State encoding (one-hot): IDLE=3'b001, GNT=3'b010, PARK=3'b100. Any other value goes to IDLE next cycle with gnt=0.
- Selection:
  - Winner is the first set req bit scanning last_id+1, last_id+2, ... modulo NUM_REQ.
  - On grant, last_id <= winner, so the winner has lowest priority next round.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: next edge -> GNT, gnt=onehot(winner), gnt_id=winner, hold_cnt=0.
  - Latency: req sampled at edge n gives gnt high after edge n+1.
- GNT:
  - hold_cnt increments each GNT cycle, saturating; width $clog2(MAX_HOLD+1).
  - req[gnt_id]==0 -> PARK, gnt=0. Releasing is the owner's only obligation.
  - req[gnt_id]==1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> PARK, gnt=0, timeout=1 for one cycle.
  - Otherwise stay in GNT, outputs unchanged.
  - Maximum grant length is exactly MAX_HOLD cycles.
  - Requests from other requesters never shorten a grant.
- PARK (turnaround, gnt=0, exactly one cycle):
  - Arbitration runs on the current req.
  - Any req -> GNT with the new winner; req==0 -> IDLE.
  - A timed-out owner still requesting may win again only if no other req bit is set (round-robin fairness).
- Simultaneous events: owner release and hold-limit reached in the same cycle count as a release; timeout stays 0.
- gnt_id holds its last value in IDLE/PARK.

Optional Feature:
- Macro: RR_GRANT_SCHED_PREEMPT_EN.
- Defined:
  - Requester 0 is urgent.
  - If req[0]==1 while in GNT with gnt_id!=0: next edge -> PARK with gnt=0 and timeout=0.
  - The following arbitration grants requester 0 regardless of last_id.
  - last_id is then set to 0, as usual.
  - An extra output port, preempt (1 bit), pulses for one cycle on the revocation.
- Not defined: preempt port absent; requester 0 is an ordinary round-robin participant.

Test Plan (NUM_REQ=4, MAX_HOLD=8):
- Reset then req=4'b1111 held -> gnt 0001 (8 cycles), timeout pulse, PARK, 0010, 0100, 1000, 0001; one zero-gnt cycle between owners.
- req=4'b0100 for 3 cycles then 0 -> gnt=0100 from edge n+1 for 3 cycles, gnt_id=2, PARK then IDLE, busy falls one cycle after PARK.
- req[1] held alone for 20 cycles -> 0010 for 8 cycles, timeout, PARK, regranted 0010; timeout pulses at each 8-cycle boundary.
- Owner req[3] drops in the same cycle hold_cnt==7 -> timeout stays 0, gnt drops, next owner granted after PARK.
- reset_n low mid-grant (gnt=0010) -> gnt=0 immediately without a clock edge; after release, req=4'b0011 gives 0001 first.
- With RR_GRANT_SCHED_PREEMPT_EN: owner 2 in GNT, req[0] rises -> next edge gnt=0 with preempt=1 and timeout=0, then gnt=0001.
